fc_mac_neuron: RTL and testbench

Sequential, parametrised successor to the fully-unrolled FC neuron (constant multipliers, adder tree, ReLU).
- Streams the IN activations and their weights in beats of LANES elements.
- Multiply-accumulates them over ceil(IN/LANES) beats and applies an optional ReLU.
- Returns one result per frame over a valid/ready handshake.
- Sits between the activation buffer/weight ROM and the next layer's input staging.

---
 rtl/fc_pkg.sv | 15 +
 rtl/fc_mac_neuron_if.sv | 27 ++
 rtl/lane_dot.sv | 30 +++
 rtl/fc_mac_neuron.sv | 104 ++++++++++
 tb/tb_fc_mac_neuron.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the sequential fully-connected MAC neuron.
package fc_pkg;

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

    // Accumulator wide enough to hold any IN-term sum of WIDTH x WIDTH products.
    function automatic int acc_width(input int width, input int n_in);
        return 2 * width + $clog2(n_in);
    endfunction

    function automatic int beats(input int n_in, input int lanes);
        return (n_in + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/fc_mac_neuron_if.sv
// Beat input stream and result output stream of the MAC neuron.
interface fc_mac_neuron_if
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int ACC_W = acc_width(8, 400)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*LANES-1:0]   in_x;
    logic [WIDTH*LANES-1:0]   in_w;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_z;

    modport master (
        output in_valid, in_x, in_w, in_last, out_ready,
        input  in_ready, out_valid, out_z
    );

    modport slave (
        input  in_valid, in_x, in_w, in_last, out_ready,
        output in_ready, out_valid, out_z
    );
endinterface

// File: rtl/lane_dot.sv
// Combinational signed dot product of one beat; masked lanes contribute zero.
module lane_dot
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int SUM_W = 2 * WIDTH + $clog2(LANES)
) (
    input  logic [WIDTH*LANES-1:0] x,
    input  logic [WIDTH*LANES-1:0] w,
    input  logic [LANES-1:0]       mask,
    output logic signed [SUM_W-1:0] sum
);
    logic signed [2*WIDTH-1:0] prod [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ws;
        assign xs = signed'(x[k*WIDTH +: WIDTH]);
        assign ws = signed'(w[k*WIDTH +: WIDTH]);
        assign prod[k] = mask[k] ? (2*WIDTH)'(xs) * (2*WIDTH)'(ws) : '0;
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            sum = sum + SUM_W'(prod[k]);
        end
    end
endmodule

// File: rtl/fc_mac_neuron.sv
// Sequential FC neuron: LANES-wide multiply-accumulate over ceil(IN/LANES) beats,
// optional ReLU, one result per frame on a valid/ready output.
module fc_mac_neuron
    import fc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int IN      = 400,
    parameter int LANES   = 4,
    parameter int RELU_EN = 1,
    parameter int ACC_W   = acc_width(WIDTH, IN)
) (
    input  logic           clk,
    input  logic           rst,
    fc_mac_neuron_if.slave bus,
    output logic           err
);
    localparam int BEATS      = beats(IN, LANES);
    localparam int LAST_LANES = IN - (BEATS - 1) * LANES;
    localparam int SUM_W      = 2 * WIDTH + $clog2(LANES);
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [LANES-1:0]        mask;
    logic signed [SUM_W-1:0] lane_sum;
    logic signed [SUM_W-1:0] prod_p1;
    logic                    vld_p1;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] z_p2;
    logic                    vld_p2;
    logic                    beat;
    logic                    last_beat;
    logic                    take;

    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] a);
        return (RELU_EN != 0 && a < 0) ? '0 : a;
    endfunction

    lane_dot #(.WIDTH(WIDTH), .LANES(LANES), .SUM_W(SUM_W)) u_dot (
        .x    (bus.in_x),
        .w    (bus.in_w),
        .mask (mask),
        .sum  (lane_sum)
    );

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = vld_p2;
    assign bus.out_z     = z_p2;

    always_comb begin
        state_nxt = state;
        last_beat = (cnt == CNT_W'(BEATS - 1));
        beat      = bus.in_valid && (state == ACCUM);
        take      = vld_p2 && bus.out_ready;
        mask      = '1;
        // The tail beat of a frame only carries LAST_LANES real elements.
        if (last_beat) begin
            for (int k = 0; k < LANES; k++) begin
                mask[k] = (k < LAST_LANES);
            end
        end
        case (state)
            ACCUM:   if (beat && last_beat) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (take) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            cnt     <= '0;
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
            acc     <= '0;
            z_p2    <= '0;
            vld_p2  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state  <= state_nxt;
            // p0 -> p1: registered lane sum of the accepted beat
            vld_p1 <= beat;
            if (beat) begin
                prod_p1 <= lane_sum;
                cnt     <= last_beat ? '0 : cnt + 1'b1;
                if (bus.in_last != last_beat) err <= 1'b1;
            end
            // p1 -> acc: frame sum, cleared once the result is handed off
            if (take) begin
                acc <= '0;
            end else if (vld_p1) begin
                acc <= acc + ACC_W'(prod_p1);
            end
            // acc -> p2: output register, held until accepted
            if (state == DONE && !vld_p2) begin
                vld_p2 <= 1'b1;
                z_p2   <= relu(acc);
            end else if (take) begin
                vld_p2 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fc_mac_neuron.sv
// Self-checking bench: four neuron configurations share one stimulus bus, selected by sel.
module tb_fc_mac_neuron;
    import fc_pkg::*;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int A0 = acc_width(W, 8);
    localparam int A2 = acc_width(W, 10);
    localparam int A3 = acc_width(W, 400);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]          sel;
    logic                in_valid, in_last, out_ready;
    logic [W*L-1:0]      in_x, in_w;
    logic                in_ready_m, out_valid_m, err_m;
    logic signed [31:0]  out_z_m;
    logic                err0, err1, err2, err3;

    fc_mac_neuron_if #(.WIDTH(W), .LANES(L), .ACC_W(A0)) if0 ();
    fc_mac_neuron_if #(.WIDTH(W), .LANES(L), .ACC_W(A0)) if1 ();
    fc_mac_neuron_if #(.WIDTH(W), .LANES(L), .ACC_W(A2)) if2 ();
    fc_mac_neuron_if #(.WIDTH(W), .LANES(L), .ACC_W(A3)) if3 ();

    fc_mac_neuron #(.WIDTH(W), .IN(8),   .LANES(L), .RELU_EN(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave), .err(err0));
    fc_mac_neuron #(.WIDTH(W), .IN(8),   .LANES(L), .RELU_EN(0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave), .err(err1));
    fc_mac_neuron #(.WIDTH(W), .IN(10),  .LANES(L), .RELU_EN(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave), .err(err2));
    fc_mac_neuron #(.WIDTH(W), .IN(400), .LANES(L), .RELU_EN(1)) u3 (.clk(clk), .rst(rst), .bus(if3.slave), .err(err3));

    assign if0.in_valid = in_valid && (sel == 2'd0);
    assign if1.in_valid = in_valid && (sel == 2'd1);
    assign if2.in_valid = in_valid && (sel == 2'd2);
    assign if3.in_valid = in_valid && (sel == 2'd3);
    assign if0.out_ready = out_ready && (sel == 2'd0);
    assign if1.out_ready = out_ready && (sel == 2'd1);
    assign if2.out_ready = out_ready && (sel == 2'd2);
    assign if3.out_ready = out_ready && (sel == 2'd3);
    assign if0.in_x = in_x;  assign if0.in_w = in_w;  assign if0.in_last = in_last;
    assign if1.in_x = in_x;  assign if1.in_w = in_w;  assign if1.in_last = in_last;
    assign if2.in_x = in_x;  assign if2.in_w = in_w;  assign if2.in_last = in_last;
    assign if3.in_x = in_x;  assign if3.in_w = in_w;  assign if3.in_last = in_last;

    always_comb begin
        in_ready_m  = 1'b0;
        out_valid_m = 1'b0;
        out_z_m     = '0;
        err_m       = 1'b0;
        case (sel)
            2'd0: begin in_ready_m = if0.in_ready; out_valid_m = if0.out_valid; out_z_m = 32'(if0.out_z); err_m = err0; end
            2'd1: begin in_ready_m = if1.in_ready; out_valid_m = if1.out_valid; out_z_m = 32'(if1.out_z); err_m = err1; end
            2'd2: begin in_ready_m = if2.in_ready; out_valid_m = if2.out_valid; out_z_m = 32'(if2.out_z); err_m = err2; end
            default: begin in_ready_m = if3.in_ready; out_valid_m = if3.out_valid; out_z_m = 32'(if3.out_z); err_m = err3; end
        endcase
    end

    typedef struct {
        int                 s;
        logic signed [31:0] z;
    } exp_t;

    typedef struct {
        int                 s;
        int                 nb;
        logic signed [7:0]  x;
        logic signed [7:0]  w;
        logic               garbage;
        int                 stall;
        logic signed [31:0] z;
    } vec_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (sel %0d, t=%0t)", name, act, req, sel, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (sel %0d, t=%0t)", name, act, req, sel, $time);
        end
    endtask

    task automatic push_exp(input int s, input logic signed [31:0] z);
        exp_t e;
        e.s = s;
        e.z = z;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rep(input logic signed [7:0] v);
        return {4{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic drive_beat(input logic [31:0] xp, input logic [31:0] wp, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_x     = xp;
        in_w     = wp;
        in_last  = last;
        while (!in_ready_m && n < 50) begin
            tick();
            n++;
        end
        chk1("beat_in_ready", in_ready_m, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int stall);
        int n = 0;
        exp_t e;
        logic signed [31:0] held;
        while (!out_valid_m && n < 300) begin
            tick();
            n++;
        end
        chk1("out_valid_seen", out_valid_m, 1'b1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got output %0d, expected none", out_z_m);
        end else begin
            e = sb.pop_front();
            chk("out_z", out_z_m, e.z);
        end
        held = out_z_m;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk1("stall_valid", out_valid_m, 1'b1);
            chk("stall_z", out_z_m, held);
            chk1("stall_in_ready", in_ready_m, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("valid_drop", out_valid_m, 1'b0);
        chk1("in_ready_back", in_ready_m, 1'b1);
    endtask

    task automatic rand_frame(input int s, input int n_in, input int nb);
        logic [31:0]       xp [4];
        logic [31:0]       wp [4];
        logic signed [7:0] xv, wv;
        int sum = 0;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < L; k++) begin
                xv = 8'($urandom);
                wv = 8'($urandom);
                xp[b][k*8 +: 8] = xv;
                wp[b][k*8 +: 8] = wv;
                if (b * L + k < n_in) sum += int'(xv) * int'(wv);
            end
        end
        sel = 2'(s);
        push_exp(s, sum);
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, 3)) tick();
            drive_beat(xp[b], wp[b], b == nb - 1);
        end
        collect(0);
    endtask

    vec_t tbl[8];

    initial begin
        logic [31:0] xp, wp;
        exp_t e;
        int n;

        tbl[0] = '{0, 2,   8'sd1,   8'sd2,   1'b0, 0, 32'sd16};
        tbl[1] = '{0, 2,   8'sd1,  -8'sd3,   1'b0, 0, 32'sd0};
        tbl[2] = '{1, 2,   8'sd1,  -8'sd3,   1'b0, 0, -32'sd24};
        tbl[3] = '{2, 3,   8'sd1,   8'sd1,   1'b1, 0, 32'sd10};
        tbl[4] = '{3, 100, 8'sh80,  8'sh80,  1'b0, 5, 32'sd6553600};
        tbl[5] = '{1, 2,   8'sh80,  8'sd127, 1'b0, 0, -32'sd130048};
        tbl[6] = '{0, 2,   8'sd127, 8'sd127, 1'b0, 0, 32'sd129032};
        tbl[7] = '{2, 3,  -8'sd5,   8'sd7,   1'b1, 2, -32'sd350};

        rst = 1'b1;
        sel = 2'd0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        in_x = '0;
        in_w = '0;
        repeat (3) tick();
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk1("rst_in_ready", in_ready_m, 1'b1);
            chk1("rst_out_valid", out_valid_m, 1'b0);
            chk("rst_out_z", out_z_m, 32'sd0);
            chk1("rst_err", err_m, 1'b0);
        end
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            sel = 2'(tbl[i].s);
            push_exp(tbl[i].s, tbl[i].z);
            for (int b = 0; b < tbl[i].nb; b++) begin
                xp = rep(tbl[i].x);
                wp = rep(tbl[i].w);
                if (tbl[i].garbage && b == tbl[i].nb - 1) begin
                    xp[31:16] = 16'h7F7F;
                    wp[31:16] = 16'h7F7F;
                end
                drive_beat(xp, wp, b == tbl[i].nb - 1);
            end
            tick();
            chk1("lat_t1_valid", out_valid_m, 1'b0);
            tick();
            chk1("lat_t2_valid", out_valid_m, 1'b1);
            collect(tbl[i].stall);
            chk1("frame_err", err_m, 1'b0);
        end

        rand_frame(1, 8, 2);
        rand_frame(1, 8, 2);
        rand_frame(2, 10, 3);
        rand_frame(2, 10, 3);

        // Result handshake and a new beat offered in the same DONE cycle.
        sel = 2'd0;
        push_exp(0, 32'sd8);
        drive_beat(rep(8'sd1), rep(8'sd1), 1'b0);
        drive_beat(rep(8'sd1), rep(8'sd1), 1'b1);
        n = 0;
        while (!out_valid_m && n < 10) begin
            tick();
            n++;
        end
        chk1("done_valid", out_valid_m, 1'b1);
        e = sb.pop_front();
        chk("done_z", out_z_m, e.z);
        push_exp(0, 32'sd16);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = rep(8'sd1);
        in_w      = rep(8'sd1);
        in_last   = 1'b0;
        chk1("done_in_ready", in_ready_m, 1'b0);
        tick();
        out_ready = 1'b0;
        chk1("reentry_in_ready", in_ready_m, 1'b1);
        chk1("reentry_valid", out_valid_m, 1'b0);
        tick();
        in_valid = 1'b0;
        drive_beat(rep(8'sd1), rep(8'sd3), 1'b1);
        collect(0);

        // Framing error: in_last on beat 0 of a two-beat frame.
        push_exp(0, 32'sd8);
        drive_beat(rep(8'sd1), rep(8'sd1), 1'b1);
        chk1("err_set", err_m, 1'b1);
        drive_beat(rep(8'sd1), rep(8'sd1), 1'b0);
        collect(0);
        chk1("err_sticky", err_m, 1'b1);

        // Asynchronous reset in the middle of a frame.
        drive_beat(rep(8'sd1), rep(8'sd1), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1("midrst_out_valid", out_valid_m, 1'b0);
        chk("midrst_out_z", out_z_m, 32'sd0);
        chk1("midrst_err", err_m, 1'b0);
        chk1("midrst_in_ready", in_ready_m, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        push_exp(0, 32'sd48);
        drive_beat(rep(8'sd2), rep(8'sd3), 1'b0);
        drive_beat(rep(8'sd2), rep(8'sd3), 1'b1);
        collect(0);
        chk1("post_rst_err", err_m, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
